// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the wait-stated data memory responder:
// FSM state encoding, access-size codes and the widths used by the error checks.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } size_t;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LANE_W = 2;                  // byte-offset bits inside a word
   localparam int WIDX_W = ADDR_W - LANE_W;    // word-index bits of a byte address
   localparam int CNT_W  = 4;                  // wait-state counter, covers 0..15

endpackage

// File: rtl/data_mem_lane.sv
// Little-endian byte-lane extraction for reads and lane merge for writes,
// plus the alignment check for halfword/word accesses. Purely combinational.
module data_mem_lane
   import data_mem_responder_pkg::*;
(
   input  size_t             size_i,
   input  logic [LANE_W-1:0] lane_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [DATA_W-1:0] wword_o,
   output logic              misalign_o
);

   logic [4:0] byte_sh;
   logic [4:0] half_sh;

   assign byte_sh = {lane_i, 3'b000};
   assign half_sh = {lane_i[1], 4'b0000};

   always_comb begin
      rdata_o    = '0;
      wword_o    = word_i;
      misalign_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            rdata_o[7:0]          = word_i[byte_sh +: 8];
            wword_o[byte_sh +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            misalign_o             = lane_i[0];
            rdata_o[15:0]          = word_i[half_sh +: 16];
            wword_o[half_sh +: 16] = wdata_i[15:0];
         end
         SZ_WORD: begin
            misalign_o = (lane_i != '0);
            rdata_o    = word_i;
            wword_o    = wdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory with a fixed number of wait states before each
// one-cycle ack; handles byte/halfword/word accesses with alignment/range errors.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                we_q;
   size_t               size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                accept, enter_resp;
   logic                acc_we;
   size_t               acc_size;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   cur_word, lane_rd, lane_wr;
   logic                misalign, out_of_range, acc_err, mem_we;

   logic [DATA_W-1:0]   mem [DEPTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // With zero wait states the access happens on the accepting edge, so the
   // fields come straight from the ports; otherwise only the latched copy is used.
   always_comb begin
      acc_we    = (state_q == ST_IDLE) ? we             : we_q;
      acc_size  = (state_q == ST_IDLE) ? size_t'(size)  : size_q;
      acc_addr  = (state_q == ST_IDLE) ? addr           : addr_q;
      acc_wdata = (state_q == ST_IDLE) ? wdata          : wdata_q;
   end

   assign idx          = acc_addr[IDX_W+LANE_W-1:LANE_W];
   assign cur_word     = mem[idx];
   assign out_of_range = acc_addr[ADDR_W-1:LANE_W] >= WIDX_W'(DEPTH);
   assign acc_err      = (acc_size != SZ_NONE) && (misalign || out_of_range);
   assign mem_we       = enter_resp && reset && acc_we && (acc_size != SZ_NONE) && !acc_err;

   data_mem_lane u_lane (
      .size_i     (acc_size),
      .lane_i     (acc_addr[LANE_W-1:0]),
      .word_i     (cur_word),
      .wdata_i    (acc_wdata),
      .rdata_o    (lane_rd),
      .wword_o    (lane_wr),
      .misalign_o (misalign)
   );

   // Successful writes leave rdata untouched; errors and size-none responses clear it.
   always_comb begin
      err_d   = enter_resp && acc_err;
      rdata_d = rdata_q;
      if (enter_resp) begin
         if (acc_err || acc_size == SZ_NONE) begin
            rdata_d = '0;
         end else if (!acc_we) begin
            rdata_d = lane_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= we;
         size_q  <= size_t'(size);
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= lane_wr;
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign ack   = (state_q == ST_RESP);
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, held-request
// and reset-abort sequences, then random traffic against a byte-array model.
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int WAITC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        busy, ack, err;
   logic [31:0] rdata;

   int n_tests = 0;
   int n_fail  = 0;

   byte unsigned mbytes [DEPTH*4];
   logic [31:0]  m_rdata;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .we    (we),
      .size  (size),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .ack   (ack),
      .err   (err),
      .rdata (rdata)
   );

   typedef struct {
      string       name;
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      logic        ee;
      logic [31:0] er;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, response computed from the access rules.
   task automatic model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic e, output logic [31:0] r);
      int n;
      case (sz)
         2'b01:   n = 1;
         2'b10:   n = 2;
         2'b11:   n = 4;
         default: n = 0;
      endcase
      e = 1'b0;
      if (n == 0) begin
         m_rdata = '0;
      end else if ((a % 32'(n)) != 0 || a >= 32'(DEPTH*4)) begin
         e = 1'b1;
         m_rdata = '0;
      end else if (w) begin
         for (int i = 0; i < n; i++) mbytes[int'(a) + i] = d[8*i +: 8];
      end else begin
         m_rdata = '0;
         for (int i = 0; i < n; i++) m_rdata[8*i +: 8] = mbytes[int'(a) + i];
      end
      r = m_rdata;
   endtask

   task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input bit noise,
                      output int lat, output logic e, output logic [31:0] r);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; addr = a; wdata = d;
      @(posedge clk);
      #1;
      req = 1'b0;
      lat = -1; e = 1'bx; r = 'x;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ack) begin
            lat = c; e = err; r = rdata;
            break;
         end
         if (noise) begin
            req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
            addr = $urandom; wdata = $urandom;
         end
      end
      req = 1'b0;
   endtask

   task automatic run_check(input string nm, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d, input bit noise,
                            input logic ee, input logic [31:0] er);
      int lat;
      logic e;
      logic [31:0] r;
      txn(w, sz, a, d, noise, lat, e, r);
      check({nm, "_lat"},   32'(lat), 32'(WAITC + 1));
      check({nm, "_err"},   {31'b0, e}, {31'b0, ee});
      check({nm, "_rdata"}, r, er);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic        ee;
      logic [31:0] er;
      logic [11:0] ack_pat, busy_pat;
      logic [31:0] held_rd;
      int          acks;

      req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      m_rdata = '0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("rst_busy",  {31'b0, busy}, 32'd0);
      check("rst_ack",   {31'b0, ack},  32'd0);
      check("rst_err",   {31'b0, err},  32'd0);
      check("rst_rdata", rdata,         32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Known contents for words 0..15: {A5, k, 3C, k}
      for (int k = 0; k < 16; k++) begin
         logic [31:0] iv;
         iv = {8'hA5, 8'(k), 8'h3C, 8'(k)};
         model(1'b1, 2'b11, 32'(k*4), iv, ee, er);
         run_check("init", 1'b1, 2'b11, 32'(k*4), iv, 1'b0, 1'b0, 32'h0);
      end

      vecs[0]  = '{"wr_w10",   1'b1, 2'b11, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{"rd_w10",   1'b0, 2'b11, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{"wr_b11",   1'b1, 2'b01, 32'h11,  32'hFFFFFF5A, 1'b0, 32'hDEADBEEF};
      vecs[3]  = '{"rd_w10b",  1'b0, 2'b11, 32'h10,  32'h0,        1'b0, 32'hDEAD5AEF};
      vecs[4]  = '{"rd_b13",   1'b0, 2'b01, 32'h13,  32'h0,        1'b0, 32'h000000DE};
      vecs[5]  = '{"rd_h11",   1'b0, 2'b10, 32'h11,  32'h0,        1'b1, 32'h0};
      vecs[6]  = '{"rd_w12",   1'b0, 2'b11, 32'h12,  32'h0,        1'b1, 32'h0};
      vecs[7]  = '{"rd_w10c",  1'b0, 2'b11, 32'h10,  32'h0,        1'b0, 32'hDEAD5AEF};
      vecs[8]  = '{"wr_w400",  1'b1, 2'b11, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0};
      vecs[9]  = '{"rd_w000",  1'b0, 2'b11, 32'h0,   32'h0,        1'b0, 32'hA5003C00};
      vecs[10] = '{"wr_h16",   1'b1, 2'b10, 32'h16,  32'hFFFF1234, 1'b0, 32'hA5003C00};
      vecs[11] = '{"rd_w14",   1'b0, 2'b11, 32'h14,  32'h0,        1'b0, 32'h12343C05};
      vecs[12] = '{"rd_h16",   1'b0, 2'b10, 32'h16,  32'h0,        1'b0, 32'h00001234};
      vecs[13] = '{"rd_b15",   1'b0, 2'b01, 32'h15,  32'h0,        1'b0, 32'h0000003C};
      vecs[14] = '{"rd_none",  1'b0, 2'b00, 32'h14,  32'h0,        1'b0, 32'h0};
      vecs[15] = '{"rd_w14b",  1'b0, 2'b11, 32'h14,  32'h0,        1'b0, 32'h12343C05};
      vecs[16] = '{"wr_none",  1'b1, 2'b00, 32'h14,  32'h0,        1'b0, 32'h0};
      vecs[17] = '{"rd_w14c",  1'b0, 2'b11, 32'h14,  32'h0,        1'b0, 32'h12343C05};

      for (int i = 0; i < 18; i++) begin
         model(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d, ee, er);
         run_check(vecs[i].name, vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d,
                   1'b0, vecs[i].ee, vecs[i].er);
      end

      // req held high across three back-to-back reads of 0x10
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b11; addr = 32'h10; wdata = '0;
      ack_pat = '0; busy_pat = '0; held_rd = '0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         ack_pat[i-1]  = ack;
         busy_pat[i-1] = busy;
         if (ack) held_rd = rdata;
         if (i == 11) req = 1'b0;
      end
      check("held_ack_pattern",  {20'b0, ack_pat},  32'h444);
      check("held_busy_pattern", {20'b0, busy_pat}, 32'h777);
      check("held_rdata",        held_rd,           32'hDEAD5AEF);
      repeat (3) model(1'b0, 2'b11, 32'h10, 32'h0, ee, er);

      // Reset asserted during the second wait state of a write to 0x20
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b11; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("abort_busy_wait1", {31'b0, busy}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy",  {31'b0, busy}, 32'd0);
      check("abort_ack",   {31'b0, ack},  32'd0);
      check("abort_err",   {31'b0, err},  32'd0);
      check("abort_rdata", rdata,         32'd0);
      m_rdata = '0;
      acks = 0;
      repeat (2) begin
         @(negedge clk);
         acks += int'(ack);
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         acks += int'(ack);
      end
      check("abort_no_ack", 32'(acks), 32'd0);
      model(1'b0, 2'b11, 32'h20, 32'h0, ee, er);
      run_check("post_abort_rd_w20", 1'b0, 2'b11, 32'h20, 32'h0, 1'b0, 1'b0, 32'hA5083C08);

      // Random traffic, with junk on the inputs while busy
      for (int t = 0; t < 250; t++) begin
         logic        w;
         logic [1:0]  sz;
         logic [31:0] a, d;
         w  = 1'($urandom);
         sz = 2'($urandom);
         d  = $urandom;
         if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
         else                           a = 32'($urandom_range(0, 63));
         model(w, sz, a, d, ee, er);
         run_check("rnd", w, sz, a, d, 1'($urandom), ee, er);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
